panda_data_responder: RTL and testbench
=======================================

Name: panda_data_responder

Overview:
- Responder on the core data port: consumes address, write data and byte write-enables from the core's memory stage, and returns read data.
- Backs a word-organised data RAM with per-byte write strobes.
- Adds a small MMIO window: 64-bit free-running cycle timer, timer compare with interrupt output, and a sticky tohost/halt register used by simulation benches to end a test.

Parameters:
- MEM_WORDS, 4096, depth of data RAM in 32-bit words (power of two).
- MMIO_BASE, 32'h8000_0000, base byte address of the MMIO window (32-byte aligned).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- data_addr_i  input  32  byte address from core; bits [1:0] ignored (word access).
- data_wdata_i  input  32  write data, byte lanes aligned to address word.
- data_we_i  input  4  byte write enables; bit i writes bits [8i+7:8i]; 4'b0000 = read.
- data_rdata_o  output  32  registered read data.
- timer_irq_o  output  1  registered, high while mtime >= mtimecmp.
- halt_o  output  1  sticky, set by any write to TOHOST.
- tohost_o  output  32  last value written to TOHOST.

Behaviour:
- Reset (rst_ni low at posedge): data_rdata_o=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, timer_irq_o=0, halt_o=0, tohost_o=0. RAM contents are not reset.
- Every cycle is an access; there is no valid/ready handshake.
- Decode on word address A = data_addr_i[31:2]:
  - RAM hit: data_addr_i < MEM_WORDS*4. Index = A[log2(MEM_WORDS)-1:0].
  - MMIO hit: data_addr_i[31:5] == MMIO_BASE[31:5].
  - Otherwise unmapped.
- MMIO offsets (addr[4:2]):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 TOHOST
  - 5-7 reserved: read 0, writes ignored.
- Read latency is exactly 1 cycle: data_rdata_o at edge N+1 reflects the address presented before edge N+1.
- Unmapped reads return 0; unmapped writes are dropped with no side effect.
- Writes take effect at the clock edge, byte-granular, for RAM and all writable MMIO registers. Byte-masked writes to MTIME/MTIMECMP halves update only enabled bytes.
- Read-during-write to the same location is read-first: data_rdata_o returns the pre-write value. Applies to RAM and MMIO.
- mtime increments by 1 every cycle and wraps 2^64-1 -> 0.
  - A write to either half that cycle replaces the increment for the whole 64-bit register: written bytes take write data, unwritten bytes hold the old value. No increment that cycle.
  - A read of MTIME_LO/HI returns the pre-edge value.
  - The low-to-high carry is a single 64-bit add, so there is no tearing inside the block.
- timer_irq_o is registered from the compare (mtime >= mtimecmp, unsigned 64-bit) using post-update register values. It asserts 1 cycle after the condition becomes true and deasserts 1 cycle after mtimecmp is raised above mtime.
- TOHOST:
  - Any write with nonzero data_we_i merges enabled bytes into tohost_o and sets halt_o.
  - halt_o clears only on reset.
  - Subsequent writes still update tohost_o.
  - A TOHOST read returns tohost_o.
- Reset asserted mid-operation: all registers return to reset values at that edge. A write presented in the same cycle as active reset is ignored for MMIO; a RAM write in that cycle is also suppressed.
- RAM is inferred as synchronous single-port, read-first, byte-enable write, suitable for FPGA block RAM.

Test Plan:
- Reset, then read addr 0x0 -> data_rdata_o=0 one cycle later. timer_irq_o=0, halt_o=0.
- Write 0xDEADBEEF to 0x10 with we=4'hF. Write 0x000000AA to 0x10 with we=4'b0001. Read 0x10 -> 0xDEADBEAA one cycle after the read address.
- Same-cycle write 0x11111111 and read at 0x20 (old 0x22222222) -> rdata 0x22222222. Next-cycle read -> 0x11111111.
- Write MTIMECMP_HI=0, MTIMECMP_LO=5 right after reset -> timer_irq_o rises the cycle after mtime reaches 5. Write MTIMECMP_LO=0xFFFF_FFFF -> timer_irq_o falls one cycle later.
- Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0. Read MTIME_HI over the following cycles -> 0 then 1 after the wrap. Reading MTIME_LO in the write cycle returns the pre-write value.
- Write 1 to TOHOST (MMIO_BASE+0x10) -> halt_o=1, tohost_o=1 next cycle. Read 0x1000_0000 (unmapped) -> 0. Pulse reset -> halt_o=0.

Source files
------------

// File: rtl/panda_data_responder.sv
// Data-port responder: word-organised byte-writable RAM plus an MMIO window
// holding a 64-bit cycle timer, its compare/interrupt, and a sticky tohost/halt register.
module panda_data_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        timer_irq_o,
    output logic        halt_o,
    output logic [31:0] tohost_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        OFF_MTIME_LO    = 3'd0,
        OFF_MTIME_HI    = 3'd1,
        OFF_MTIMECMP_LO = 3'd2,
        OFF_MTIMECMP_HI = 3'd3,
        OFF_TOHOST      = 3'd4
    } mmio_off_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode
    logic             ram_hit;
    logic             mmio_hit;
    logic             we_any;
    logic [IDX_W-1:0] ram_idx;
    logic [2:0]       mmio_off;

    assign ram_hit  = {1'b0, data_addr_i} < RAM_BYTES;
    assign mmio_hit = data_addr_i[31:5] == MMIO_BASE[31:5];
    assign we_any   = |data_we_i;
    assign ram_idx  = data_addr_i[IDX_W+1:2];
    assign mmio_off = data_addr_i[4:2];

    // MMIO state
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_next;
    logic [31:0] tohost;
    logic        halt;
    logic        irq;

    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_tohost;

    always_comb begin
        wr_mtime_lo = 1'b0;
        wr_mtime_hi = 1'b0;
        wr_cmp_lo   = 1'b0;
        wr_cmp_hi   = 1'b0;
        wr_tohost   = 1'b0;
        if (mmio_hit && we_any) begin
            case (mmio_off)
                OFF_MTIME_LO:    wr_mtime_lo = 1'b1;
                OFF_MTIME_HI:    wr_mtime_hi = 1'b1;
                OFF_MTIMECMP_LO: wr_cmp_lo   = 1'b1;
                OFF_MTIMECMP_HI: wr_cmp_hi   = 1'b1;
                OFF_TOHOST:      wr_tohost   = 1'b1;
                default: ;
            endcase
        end
    end

    // A write to either timer half replaces that cycle's increment for all 64 bits
    always_comb begin
        mtime_next = mtime + 64'd1;
        if (wr_mtime_lo || wr_mtime_hi) begin
            mtime_next = mtime;
            if (wr_mtime_lo) mtime_next[31:0]  = merge_bytes(mtime[31:0],  data_wdata_i, data_we_i);
            if (wr_mtime_hi) mtime_next[63:32] = merge_bytes(mtime[63:32], data_wdata_i, data_we_i);
        end
    end

    always_comb begin
        mtimecmp_next = mtimecmp;
        if (wr_cmp_lo) mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0],  data_wdata_i, data_we_i);
        if (wr_cmp_hi) mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], data_wdata_i, data_we_i);
    end

    // MMIO read mux sees pre-edge values, giving read-first semantics
    logic [31:0] mmio_rd;
    always_comb begin
        mmio_rd = 32'd0;
        if (mmio_hit) begin
            case (mmio_off)
                OFF_MTIME_LO:    mmio_rd = mtime[31:0];
                OFF_MTIME_HI:    mmio_rd = mtime[63:32];
                OFF_MTIMECMP_LO: mmio_rd = mtimecmp[31:0];
                OFF_MTIMECMP_HI: mmio_rd = mtimecmp[63:32];
                OFF_TOHOST:      mmio_rd = tohost;
                default:         mmio_rd = 32'd0;
            endcase
        end
    end

    logic [31:0] mmio_q;
    logic        ram_sel_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            tohost    <= 32'd0;
            halt      <= 1'b0;
            irq       <= 1'b0;
            mmio_q    <= 32'd0;
            ram_sel_q <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            irq       <= mtime_next >= mtimecmp_next;
            mmio_q    <= mmio_rd;
            ram_sel_q <= ram_hit;
            if (wr_tohost) begin
                tohost <= merge_bytes(tohost, data_wdata_i, data_we_i);
                halt   <= 1'b1;
            end
        end
    end

    // Block-RAM style array: no reset on contents or read register
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] ram_q;
    logic        ram_wr_en;

    assign ram_wr_en = ram_hit && rst_ni;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_wr_en && data_we_i[i]) mem[ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
        ram_q <= mem[ram_idx];
    end

    assign data_rdata_o = ram_sel_q ? ram_q : mmio_q;
    assign timer_irq_o  = irq;
    assign halt_o       = halt;
    assign tohost_o     = tohost;

endmodule

// File: tb/tb_panda_data_responder.sv
// Directed bench for panda_data_responder: RAM, timer/compare, tohost and reset behaviour.
module tb_panda_data_responder;

    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_we_i;
    logic [31:0] data_rdata_o;
    logic        timer_irq_o;
    logic        halt_o;
    logic [31:0] tohost_o;

    int errs = 0;
    int checks = 0;

    panda_data_responder #(.MEM_WORDS(4096), .MMIO_BASE(MB)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_we_i    (data_we_i),
        .data_rdata_o (data_rdata_o),
        .timer_irq_o  (timer_irq_o),
        .halt_o       (halt_o),
        .tohost_o     (tohost_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        data_addr_i  = a;
        data_wdata_i = d;
        data_we_i    = we;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(32'h0, 32'h0, 4'h0);
        tick; tick;
        chk("rst_rdata",  data_rdata_o, 32'h0);
        chk("rst_irq",    {31'd0, timer_irq_o}, 32'd0);
        chk("rst_halt",   {31'd0, halt_o}, 32'd0);
        chk("rst_tohost", tohost_o, 32'h0);

        // Timer compare: mtime counts 1,2,... from the first released edge
        rst_ni = 1'b1;
        drive(MB + 32'hC, 32'h0, 4'hF); tick;          // mtime=1, cmp=0000_0000_FFFF_FFFF
        drive(MB + 32'h8, 32'h5, 4'hF); tick;          // mtime=2, cmp=5
        chk("irq_cmp_set", {31'd0, timer_irq_o}, 32'd0);
        drive(32'h0, 32'h0, 4'h0); tick; tick;         // mtime=4
        chk("irq_before", {31'd0, timer_irq_o}, 32'd0);
        drive(MB + 32'h0, 32'h0, 4'h0); tick;          // mtime=5
        chk("mtime_lo_4", data_rdata_o, 32'd4);
        chk("irq_rise",   {31'd0, timer_irq_o}, 32'd1);
        drive(MB + 32'h8, 32'hFFFF_FFFF, 4'hF); tick;  // mtime=6
        chk("cmp_lo_rf",  data_rdata_o, 32'd5);
        chk("irq_fall",   {31'd0, timer_irq_o}, 32'd0);

        // mtime write and carry into the high half
        drive(MB + 32'h0, 32'hFFFF_FFFE, 4'hF); tick;
        chk("mtime_lo_rf", data_rdata_o, 32'd6);
        drive(MB + 32'h4, 32'h0, 4'hF); tick;          // mtime=0_FFFFFFFE held
        chk("irq_wr_hold", {31'd0, timer_irq_o}, 32'd0);
        drive(MB + 32'h4, 32'h0, 4'h0); tick;          // mtime->0_FFFFFFFF
        chk("mtime_hi_a", data_rdata_o, 32'd0);
        chk("irq_eq",     {31'd0, timer_irq_o}, 32'd1);
        tick;
        chk("mtime_hi_b", data_rdata_o, 32'd0);
        tick;
        chk("mtime_hi_c", data_rdata_o, 32'd1);

        // RAM byte writes and read-first
        drive(32'h10, 32'hDEAD_BEEF, 4'hF); tick;
        drive(32'h10, 32'h0000_00AA, 4'b0001); tick;
        drive(32'h10, 32'h0, 4'h0); tick;
        chk("ram_bytewr", data_rdata_o, 32'hDEAD_BEAA);
        drive(32'h20, 32'h2222_2222, 4'hF); tick;
        drive(32'h20, 32'h1111_1111, 4'hF); tick;
        chk("ram_rdfirst", data_rdata_o, 32'h2222_2222);
        drive(32'h20, 32'h0, 4'h0); tick;
        chk("ram_after",   data_rdata_o, 32'h1111_1111);

        // RAM top word, and an out-of-range write that must not alias to word 0
        drive(32'h3FFC, 32'hCAFE_F00D, 4'hF); tick;
        drive(32'h0, 32'h1234_5678, 4'hF); tick;
        drive(32'h4000, 32'h9999_9999, 4'hF); tick;
        drive(32'h3FFC, 32'h0, 4'h0); tick;
        chk("ram_top",   data_rdata_o, 32'hCAFE_F00D);
        drive(32'h0, 32'h0, 4'h0); tick;
        chk("ram_noalias", data_rdata_o, 32'h1234_5678);
        drive(32'h4000, 32'h0, 4'h0); tick;
        chk("unmap_4000", data_rdata_o, 32'h0);

        // Reserved MMIO slot
        drive(MB + 32'h14, 32'hFFFF_FFFF, 4'hF); tick;
        drive(MB + 32'h14, 32'h0, 4'h0); tick;
        chk("mmio_rsvd", data_rdata_o, 32'h0);

        // TOHOST / halt
        drive(MB + 32'h10, 32'h1, 4'hF); tick;
        chk("halt_set",  {31'd0, halt_o}, 32'd1);
        chk("tohost_1",  tohost_o, 32'h1);
        drive(MB + 32'h10, 32'h0000_AB00, 4'b0010); tick;
        chk("tohost_rd", data_rdata_o, 32'h1);
        chk("tohost_mg", tohost_o, 32'h0000_AB01);
        chk("halt_stk",  {31'd0, halt_o}, 32'd1);
        drive(32'h1000_0000, 32'h0, 4'h0); tick;
        chk("unmap_rd",  data_rdata_o, 32'h0);

        // Reset mid-operation with writes presented: both must be dropped
        rst_ni = 1'b0;
        drive(32'h10, 32'h5555_5555, 4'hF); tick;
        chk("rst2_halt",   {31'd0, halt_o}, 32'd0);
        chk("rst2_tohost", tohost_o, 32'h0);
        chk("rst2_rdata",  data_rdata_o, 32'h0);
        drive(MB + 32'h10, 32'h7, 4'hF); tick;
        chk("rst2_tohwr",  tohost_o, 32'h0);
        rst_ni = 1'b1;
        drive(32'h10, 32'h0, 4'h0); tick;               // mtime 0->1
        chk("rst2_ram",    data_rdata_o, 32'hDEAD_BEAA);
        drive(MB + 32'h0, 32'h0, 4'h0); tick;
        chk("rst2_mtime",  data_rdata_o, 32'd1);
        drive(MB + 32'hC, 32'h0, 4'h0); tick;
        chk("rst2_cmphi",  data_rdata_o, 32'hFFFF_FFFF);
        chk("rst2_irq",    {31'd0, timer_irq_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
